decoder_out_buffer: RTL

DECODER_OUT_BUFFER -- requirements
Module: decoder_out_buffer

---
 rtl/decoder_out_buffer.sv | 131 +++++++++++++
 1 files changed

// File: rtl/decoder_out_buffer.sv
// Decoder output buffer: queues whole decoded frames in a small FIFO and
// serializes them MSB-first over a valid/ready bit stream.
`ifndef DATA_FRAME_LENGTH
`define DATA_FRAME_LENGTH 8
`endif

module decoder_out_buffer #(
    parameter int FRAME_LEN = `DATA_FRAME_LENGTH,
    parameter int DEPTH     = 2
) (
    input  logic                         sys_clk,
    input  logic                         rst,
    input  logic [FRAME_LEN-1:0]         i_frame,
    input  logic                         i_frame_valid,
    input  logic                         i_bit_ready,
    output logic                         o_bit,
    output logic                         o_bit_valid,
    output logic                         o_frame_start,
    output logic                         o_frame_last,
    output logic [$clog2(DEPTH+1)-1:0]   o_fifo_count,
    output logic                         o_overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int BW = $clog2(FRAME_LEN);
    localparam logic [BW-1:0] LAST_IDX = BW'(FRAME_LEN-1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                 r_state, w_next_state;
    logic [FRAME_LEN-1:0]   r_mem [DEPTH];
    logic [PW-1:0]          r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]          r_count;
    logic [FRAME_LEN-1:0]   r_shift;
    logic [BW-1:0]          r_bit_cnt;
    logic                   r_overflow;

    logic w_empty, w_full, w_xfer, w_last, w_load, w_push, w_drop;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FULL_CNT);
    assign w_xfer  = (r_state == SHIFT) && i_bit_ready;
    assign w_last  = (r_bit_cnt == LAST_IDX);
    // A pop on the same edge frees the slot, so a full FIFO can still accept.
    assign w_push  = i_frame_valid && (!w_full || w_load);
    assign w_drop  = i_frame_valid && w_full && !w_load;

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_load       = 1'b1;
                    w_next_state = SHIFT;
                end
            end
            SHIFT: begin
                // Back-to-back frames reload on the last-bit edge with no bubble.
                if (w_xfer && w_last) begin
                    if (!w_empty) w_load = 1'b1;
                    else          w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= i_frame;
            r_wr_ptr        <= r_wr_ptr + PW'(1);
        end
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
        end else if (w_load) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            case ({w_push, w_load})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end else if (w_load) begin
            r_shift   <= r_mem[r_rd_ptr];
            r_bit_cnt <= '0;
        end else if (w_xfer) begin
            r_shift   <= r_shift << 1;
            r_bit_cnt <= w_last ? '0 : r_bit_cnt + BW'(1);
        end
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst)         r_overflow <= 1'b0;
        else if (w_drop) r_overflow <= 1'b1;
    end

    assign o_bit_valid   = (r_state == SHIFT);
    assign o_bit         = r_shift[FRAME_LEN-1];
    assign o_frame_start = (r_state == SHIFT) && (r_bit_cnt == '0);
    assign o_frame_last  = (r_state == SHIFT) && w_last;
    assign o_fifo_count  = r_count;
    assign o_overflow    = r_overflow;

endmodule
